// File: rtl/acc_fpu_rob.sv
// FPU lane dispatch with a reorder buffer that writes results back in issue order.
// It also accumulates sticky FP status flags from every retired operation.
module acc_fpu_rob #(
  parameter int NUM_LANES  = 2,
  parameter int ROB_DEPTH  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int REQ_WIDTH  = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int TAG_WIDTH  = $clog2(ROB_DEPTH),
  parameter int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            issue_valid_i,
  output logic                            issue_ready_o,
  input  logic [REQ_WIDTH-1:0]            issue_req_i,
  input  logic [ADDR_WIDTH-1:0]           issue_waddr_i,
  output logic [NUM_LANES-1:0]            lane_valid_o,
  input  logic [NUM_LANES-1:0]            lane_ready_i,
  output logic [REQ_WIDTH-1:0]            lane_req_o,
  output logic [TAG_WIDTH-1:0]            lane_tag_o,
  output logic                            lane_flush_o,
  input  logic [NUM_LANES-1:0]            lane_resp_valid_i,
  output logic [NUM_LANES-1:0]            lane_resp_ready_o,
  input  logic [NUM_LANES*TAG_WIDTH-1:0]  lane_resp_tag_i,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_resp_data_i,
  input  logic [NUM_LANES*5-1:0]          lane_resp_status_i,
  output logic                            wb_valid_o,
  input  logic                            wb_ready_i,
  output logic [ADDR_WIDTH-1:0]           wb_waddr_o,
  output logic [DATA_WIDTH-1:0]           wb_wdata_o,
  input  logic                            flush_i,
  output logic [4:0]                      fflags_o,
  input  logic                            fflags_clr_i,
  output logic [TAG_WIDTH:0]              count_o,
  output logic                            busy_o
);

  localparam int CNT_W = TAG_WIDTH + 1;

  logic [ROB_DEPTH-1:0]  alloc_q;
  logic [ROB_DEPTH-1:0]  done_q;
  logic [ADDR_WIDTH-1:0] waddr_q  [ROB_DEPTH];
  logic [DATA_WIDTH-1:0] data_q   [ROB_DEPTH];
  logic [4:0]            status_q [ROB_DEPTH];

  logic [TAG_WIDTH-1:0] head_q;
  logic [TAG_WIDTH-1:0] tail_q;
  logic [CNT_W-1:0]     count_q;
  logic [LANE_W-1:0]    rr_q;
  logic [4:0]           fflags_q;

  logic [LANE_W-1:0]    sel_lane;
  logic [LANE_W-1:0]    cand;
  logic                 sel_found;
  logic [LANE_W-1:0]    rr_nxt;
  logic                 full;
  logic                 dispatch;
  logic                 retire;

  logic [TAG_WIDTH-1:0] resp_tag [NUM_LANES];
  logic [NUM_LANES-1:0] resp_ok;
  logic [NUM_LANES-1:0] resp_hit;

  // Round-robin search for the first ready lane starting at rr_q
  always_comb begin
    sel_lane  = '0;
    sel_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = LANE_W'((32'(rr_q) + 32'(i)) % NUM_LANES);
      if (!sel_found && lane_ready_i[cand]) begin
        sel_found = 1'b1;
        sel_lane  = cand;
      end
    end
  end

  assign rr_nxt = LANE_W'((32'(sel_lane) + 32'd1) % NUM_LANES);

  assign full          = (count_q == CNT_W'(ROB_DEPTH));
  assign issue_ready_o = !flush_i && !full && (|lane_ready_i);
  assign dispatch      = issue_valid_i && issue_ready_o;

  assign lane_valid_o = dispatch ? (NUM_LANES'(1) << sel_lane) : '0;
  assign lane_req_o   = issue_req_i;
  assign lane_tag_o   = tail_q;
  assign lane_flush_o = flush_i;

  assign lane_resp_ready_o = '1;

  always_comb begin
    resp_ok  = '0;
    resp_hit = '0;
    for (int j = 0; j < NUM_LANES; j++) begin
      resp_tag[j] = lane_resp_tag_i[j*TAG_WIDTH +: TAG_WIDTH];
      resp_ok[j]  = alloc_q[resp_tag[j]] && !done_q[resp_tag[j]];
      resp_hit[j] = lane_resp_valid_i[j] && resp_ok[j];
    end
  end

  assign wb_valid_o = alloc_q[head_q] && done_q[head_q];
  assign wb_waddr_o = waddr_q[head_q];
  assign wb_wdata_o = data_q[head_q];
  assign retire     = wb_valid_o && wb_ready_i && !flush_i;

  assign fflags_o = fflags_q;
  assign count_o  = count_q;
  assign busy_o   = (count_q != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alloc_q  <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      fflags_q <= '0;
      for (int e = 0; e < ROB_DEPTH; e++) begin
        waddr_q[e]  <= '0;
        data_q[e]   <= '0;
        status_q[e] <= '0;
      end
    end else if (flush_i) begin
      alloc_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      if (fflags_clr_i) fflags_q <= '0;
    end else begin
      if (dispatch) begin
        alloc_q[tail_q] <= 1'b1;
        done_q[tail_q]  <= 1'b0;
        waddr_q[tail_q] <= issue_waddr_i;
        tail_q          <= tail_q + 1'b1;
        rr_q            <= rr_nxt;
      end
      // Late results can only target allocated, not-yet-done slots
      for (int j = 0; j < NUM_LANES; j++) begin
        if (resp_hit[j]) begin
          done_q[resp_tag[j]]   <= 1'b1;
          data_q[resp_tag[j]]   <= lane_resp_data_i[j*DATA_WIDTH +: DATA_WIDTH];
          status_q[resp_tag[j]] <= lane_resp_status_i[j*5 +: 5];
        end
      end
      if (retire) begin
        alloc_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + 1'b1;
        fflags_q        <= (fflags_clr_i ? 5'b0 : fflags_q) | status_q[head_q];
      end else if (fflags_clr_i) begin
        fflags_q <= '0;
      end
      if (dispatch && !retire)      count_q <= count_q + 1'b1;
      else if (!dispatch && retire) count_q <= count_q - 1'b1;
    end
  end

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_resp_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
      lane_resp_valid_i[j] |-> resp_ok[j]);
  end

endmodule

// File: tb/tb_acc_fpu_rob.sv
// Scoreboard bench for acc_fpu_rob: expected writebacks are queued at issue
// and a negedge monitor compares every accepted writeback in order.
module tb_acc_fpu_rob;
  localparam int NL = 2;
  localparam int RD = 4;
  localparam int DW = 32;
  localparam int RW = 128;
  localparam int AW = 5;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           issue_valid = 0;
  logic           issue_ready;
  logic [RW-1:0]  issue_req = '0;
  logic [AW-1:0]  issue_waddr = '0;
  logic [NL-1:0]  lane_valid;
  logic [NL-1:0]  lane_ready = '0;
  logic [RW-1:0]  lane_req;
  logic [TW-1:0]  lane_tag;
  logic           lane_flush;
  logic [NL-1:0]  resp_valid = '0;
  logic [NL-1:0]  resp_ready;
  logic [NL*TW-1:0] resp_tag = '0;
  logic [NL*DW-1:0] resp_data = '0;
  logic [NL*5-1:0]  resp_status = '0;
  logic           wb_valid;
  logic           wb_ready = 0;
  logic [AW-1:0]  wb_waddr;
  logic [DW-1:0]  wb_wdata;
  logic           flush = 0;
  logic [4:0]     fflags;
  logic           fflags_clr = 0;
  logic [TW:0]    count;
  logic           busy;

  acc_fpu_rob #(
    .NUM_LANES(NL), .ROB_DEPTH(RD), .DATA_WIDTH(DW),
    .REQ_WIDTH(RW), .ADDR_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
    .issue_req_i(issue_req), .issue_waddr_i(issue_waddr),
    .lane_valid_o(lane_valid), .lane_ready_i(lane_ready),
    .lane_req_o(lane_req), .lane_tag_o(lane_tag),
    .lane_flush_o(lane_flush),
    .lane_resp_valid_i(resp_valid), .lane_resp_ready_o(resp_ready),
    .lane_resp_tag_i(resp_tag), .lane_resp_data_i(resp_data),
    .lane_resp_status_i(resp_status),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready),
    .wb_waddr_o(wb_waddr), .wb_wdata_o(wb_wdata),
    .flush_i(flush), .fflags_o(fflags), .fflags_clr_i(fflags_clr),
    .count_o(count), .busy_o(busy)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  wb_t sb[$];
  wb_t exp_e;
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [NL-1:0] lv, input logic [TW-1:0] tg,
                      input bit push);
    issue_valid = 1'b1;
    issue_waddr = a;
    issue_req   = {4{d}};
    #2;
    chk("disp_lane_valid", 64'(lane_valid), 64'(lv));
    chk("disp_tag", 64'(lane_tag), 64'(tg));
    chk("disp_req", 64'(lane_req[63:0]), {d, d});
    if (push) sb.push_back('{a: a, d: d});
    step();
    issue_valid = 1'b0;
  endtask

  task automatic rsp(input int l, input logic [TW-1:0] t,
                     input logic [DW-1:0] d, input logic [4:0] s);
    resp_valid[l]          = 1'b1;
    resp_tag[l*TW +: TW]   = t;
    resp_data[l*DW +: DW]  = d;
    resp_status[l*5 +: 5]  = s;
  endtask

  task automatic rsp_clr();
    resp_valid  = '0;
    resp_tag    = '0;
    resp_data   = '0;
    resp_status = '0;
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready && !flush) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected act=%0h/%0h exp=none",
                 wb_waddr, wb_wdata);
      end else begin
        exp_e = sb.pop_front();
        if (wb_waddr !== exp_e.a || wb_wdata !== exp_e.d) begin
          failures++;
          $display("FAIL wb_order act=%0h/%0h exp=%0h/%0h",
                   wb_waddr, wb_wdata, exp_e.a, exp_e.d);
        end
      end
    end
  end

  initial begin
    repeat (2) step();
    chk("rst_count", 64'(count), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_fflags", 64'(fflags), 0);
    chk("rst_wb_valid", 64'(wb_valid), 0);
    rst_n = 1'b1;
    step();

    // back-to-back round-robin dispatch
    lane_ready = 2'b11;
    wb_ready   = 1'b1;
    disp(5'd1, 32'hA, 2'b01, 2'd0, 1);
    disp(5'd2, 32'hB, 2'b10, 2'd1, 1);
    disp(5'd3, 32'hC, 2'b01, 2'd2, 1);
    #2;
    chk("t1_count", 64'(count), 3);
    chk("t1_busy", 64'(busy), 1);

    // out-of-order completion, in-order retire, sticky flags
    rsp(1, 2'd1, 32'hB, 5'b10000);
    step();
    rsp_clr();
    #2 chk("t2_hold0", 64'(wb_valid), 0);
    step();
    #2 chk("t2_hold1", 64'(wb_valid), 0);
    rsp(0, 2'd0, 32'hA, 5'b00001);
    #2 chk("t2_no_bypass", 64'(wb_valid), 0);
    step();
    rsp_clr();
    #2 chk("t2_wb_first", 64'(wb_valid), 1);
    step();
    #2 chk("t2_wb_second", 64'(wb_valid), 1);
    chk("t2_fflags_a", 64'(fflags), 5'b00001);
    step();
    #2 chk("t2_wb_idle", 64'(wb_valid), 0);
    chk("t2_fflags_b", 64'(fflags), 5'b10001);
    chk("t2_count", 64'(count), 1);
    rsp(0, 2'd2, 32'hC, 5'b00000);
    step();
    rsp_clr();
    step();
    #2 chk("t2_drained", 64'(count), 0);
    chk("t2_busy", 64'(busy), 0);

    // flush with a colliding lane response
    disp(5'd9,  32'h90, 2'b10, 2'd3, 0);
    disp(5'd10, 32'h91, 2'b01, 2'd0, 0);
    disp(5'd11, 32'h92, 2'b10, 2'd1, 0);
    flush = 1'b1;
    rsp(0, 2'd3, 32'hDEAD, 5'b11111);
    #2 chk("fl_lane_flush", 64'(lane_flush), 1);
    chk("fl_issue_ready", 64'(issue_ready), 0);
    step();
    flush = 1'b0;
    rsp_clr();
    #2 chk("fl_count", 64'(count), 0);
    chk("fl_busy", 64'(busy), 0);
    chk("fl_wb_valid", 64'(wb_valid), 0);
    chk("fl_fflags", 64'(fflags), 5'b10001);
    step();

    // fill, full stall during a retire, wrap to tag 0
    disp(5'd4, 32'h40, 2'b01, 2'd0, 1);
    disp(5'd5, 32'h50, 2'b10, 2'd1, 1);
    disp(5'd6, 32'h60, 2'b01, 2'd2, 1);
    disp(5'd7, 32'h70, 2'b10, 2'd3, 1);
    issue_valid = 1'b1;
    issue_waddr = 5'd8;
    #2 chk("full_ready", 64'(issue_ready), 0);
    chk("full_lane_valid", 64'(lane_valid), 0);
    chk("full_count", 64'(count), 4);
    rsp(1, 2'd0, 32'h40, 5'b00100);
    step();
    rsp_clr();
    fflags_clr = 1'b1;
    #2 chk("full_ret_wb", 64'(wb_valid), 1);
    chk("full_ret_ready", 64'(issue_ready), 0);
    chk("full_ret_lane", 64'(lane_valid), 0);
    step();
    fflags_clr = 1'b0;
    #2 chk("full_after_count", 64'(count), 3);
    chk("clr_fflags", 64'(fflags), 5'b00100);
    disp(5'd8, 32'h80, 2'b01, 2'd0, 1);
    #2 chk("refill_count", 64'(count), 4);

    // writeback stall with dual-lane capture
    wb_ready = 1'b0;
    rsp(0, 2'd1, 32'h50, 5'b00000);
    rsp(1, 2'd2, 32'h60, 5'b00000);
    step();
    rsp_clr();
    for (int c = 0; c < 5; c++) begin
      #2 chk("stall_valid", 64'(wb_valid), 1);
      chk("stall_waddr", 64'(wb_waddr), 5);
      chk("stall_wdata", 64'(wb_wdata), 32'h50);
      chk("stall_count", 64'(count), 4);
      step();
    end
    wb_ready = 1'b1;
    rsp(0, 2'd3, 32'h70, 5'b00000);
    rsp(1, 2'd0, 32'h80, 5'b00000);
    step();
    rsp_clr();
    repeat (5) step();
    #2 chk("final_count", 64'(count), 0);
    chk("sb_drain", 64'(sb.size()), 0);

    // asynchronous reset mid-operation
    disp(5'd12, 32'hC0, 2'b10, 2'd1, 0);
    #2 chk("pre_rst_count", 64'(count), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(count), 0);
    chk("arst_busy", 64'(busy), 0);
    chk("arst_fflags", 64'(fflags), 0);
    chk("arst_wb_valid", 64'(wb_valid), 0);
    step();
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
